// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: instruction-memory request/response, redirect input and the
// valid/ready instruction output towards decode.
interface inst_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus4;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, pc_plus4,
    input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, pc_plus4,
    output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// MIPS fetch stage: one outstanding imem request, inst_valid L+1 cycles after imem_req.
// Holds the instruction stable until inst_ready; redirects squash in-flight or held words.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         resetn,
  inst_fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] inst_r_q, inst_r_d;
  logic [31:0] inst_pc_r_q, inst_pc_r_d;
  logic [31:0] redirect_tgt;
  logic        unused_pc_lsbs;

  assign redirect_tgt   = {bus.redirect_pc[31:2], 2'b00};
  assign unused_pc_lsbs = ^bus.redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      inst_r_q    <= 32'h0;
      inst_pc_r_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      inst_r_q    <= inst_r_d;
      inst_pc_r_q <= inst_pc_r_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_d      = kill_q;
    inst_r_d    = inst_r_q;
    inst_pc_r_d = inst_pc_r_q;
    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        if (bus.redirect_valid) pc_d = redirect_tgt;
      end
      REQ: begin
        state_d = WAIT;
        if (bus.redirect_valid) begin
          pc_d   = redirect_tgt;
          kill_d = 1'b1;
        end
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          // A response is dropped if it was squashed earlier or is squashed right now.
          if (kill_q || bus.redirect_valid) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            inst_r_d    = bus.imem_rdata;
            inst_pc_r_d = pc_q;
            state_d     = HOLD;
          end
        end else if (bus.redirect_valid) begin
          kill_d = 1'b1;
        end
        if (bus.redirect_valid) pc_d = redirect_tgt;
      end
      HOLD: begin
        if (bus.inst_ready) begin
          state_d = REQ;
          pc_d    = bus.redirect_valid ? redirect_tgt : pc_q + 32'd4;
        end else if (bus.redirect_valid) begin
          state_d = REQ;
          pc_d    = redirect_tgt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.imem_req   = (state_q == REQ);
  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = (state_q == HOLD);
  assign bus.inst       = inst_r_q;
  assign bus.inst_pc    = inst_pc_r_q;
  assign bus.pc_plus4   = inst_pc_r_q + 32'd4;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: scoreboarded request addresses and handoffs against a latency-L memory model,
// plus a second instance reset at the top of the address space for the PC-wrap case.
module tb_inst_fetch;

  typedef struct packed {
    logic [31:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  inst_fetch_if if0 ();
  inst_fetch_if if1 ();

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut0 (.clk(clk), .resetn(resetn), .bus(if0));
  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut1 (.clk(clk), .resetn(resetn), .bus(if1));

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_addr_q[$];
  exp_t        exp_inst_q[$];
  int          req_edge_q[$];
  int          rel_edges = 0;
  int          req_cnt   = 0;
  int          hand_cnt  = 0;
  int          lat       = 1;
  int          pend_cnt  = 0;
  logic [31:0] pend_addr = 32'h0;
  logic        w_req_d   = 1'b0;
  logic [31:0] w_addr_d  = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'h8C01, a[15:0]};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid0(input string tag);
    for (int n = 0; n < 40 && !if0.inst_valid; n++) tick();
    check_val(tag, 32'(if0.inst_valid), 32'd1);
  endtask

  task automatic wait_req1(input string tag);
    for (int n = 0; n < 40 && !if1.imem_req; n++) tick();
    check_val(tag, 32'(if1.imem_req), 32'd1);
  endtask

  task automatic wait_valid1(input string tag);
    for (int n = 0; n < 40 && !if1.inst_valid; n++) tick();
    check_val(tag, 32'(if1.inst_valid), 32'd1);
  endtask

  always @(posedge clk) begin
    if (!resetn) rel_edges = 0;
    else         rel_edges++;
  end

  // Memory model and scoreboard for dut0; inputs from the stimulus change at posedge+2, so they are stable here.
  always @(negedge clk) begin
    if (!resetn) begin
      pend_cnt        = 0;
      if0.imem_rvalid = 1'b0;
      if0.imem_rdata  = 32'h0;
    end else begin
      if (if0.imem_req) begin
        check_val("one_outstanding", 32'(pend_cnt), 32'd0);
        req_edge_q.push_back(rel_edges);
        req_cnt++;
        check_val("req_expected", 32'(exp_addr_q.size() != 0), 32'd1);
        if (exp_addr_q.size() != 0) check_val("req_addr", if0.imem_addr, exp_addr_q.pop_front());
      end
      if (if0.inst_valid && if0.inst_ready) begin
        hand_cnt++;
        check_val("handoff_expected", 32'(exp_inst_q.size() != 0), 32'd1);
        if (exp_inst_q.size() != 0) begin
          exp_t e;
          e = exp_inst_q.pop_front();
          check_val("hand_inst", if0.inst, mem_word(e.pc));
          check_val("hand_pc", if0.inst_pc, e.pc);
          check_val("hand_plus4", if0.pc_plus4, e.pc + 32'd4);
        end
      end
      if0.imem_rvalid = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          if0.imem_rvalid = 1'b1;
          if0.imem_rdata  = mem_word(pend_addr);
        end
      end
      if (if0.imem_req) begin
        pend_addr = if0.imem_addr;
        pend_cnt  = lat;
      end
    end
  end

  // Fixed L=1 memory for dut1.
  always @(negedge clk) begin
    if (!resetn) begin
      w_req_d         = 1'b0;
      if1.imem_rvalid = 1'b0;
      if1.imem_rdata  = 32'h0;
    end else begin
      if1.imem_rvalid = w_req_d;
      if1.imem_rdata  = mem_word(w_addr_d);
      w_req_d         = if1.imem_req;
      w_addr_d        = if1.imem_addr;
    end
  end

  initial begin
    int exp_e[3];
    int r0;
    int h0;
    logic [31:0] held_inst;
    logic [31:0] held_pc;
    exp_e = '{1, 4, 7};

    resetn             = 1'b0;
    if0.redirect_valid = 1'b0;
    if0.redirect_pc    = 32'h0;
    if0.inst_ready     = 1'b1;
    if1.redirect_valid = 1'b0;
    if1.redirect_pc    = 32'h0;
    if1.inst_ready     = 1'b0;
    lat                = 1;

    // Reset sequence
    repeat (3) tick();
    check_val("rst_req", 32'(if0.imem_req), 32'd0);
    check_val("rst_addr", if0.imem_addr, 32'h0);
    check_val("rst_valid", 32'(if0.inst_valid), 32'd0);
    check_val("rst_inst", if0.inst, 32'h0);
    check_val("rst_inst_pc", if0.inst_pc, 32'h0);
    check_val("rst_plus4", if0.pc_plus4, 32'h4);
    check_val("rst1_addr", if1.imem_addr, 32'hFFFF_FFFC);
    foreach (exp_e[i]) begin
      exp_addr_q.push_back(32'(exp_e[i] - 1) * 32'd4 / 32'd3);
      exp_inst_q.push_back('{pc: 32'(exp_e[i] - 1) * 32'd4 / 32'd3});
    end
    exp_addr_q.push_back(32'hC);
    resetn = 1'b1;
    for (int n = 0; n < 60 && hand_cnt < 3; n++) tick();
    check_val("seq_handoffs", 32'(hand_cnt), 32'd3);
    if0.inst_ready = 1'b0;
    foreach (exp_e[i]) begin
      check_val("req_edge_avail", 32'(req_edge_q.size() != 0), 32'd1);
      if (req_edge_q.size() != 0) check_val("req_edge", 32'(req_edge_q.pop_front()), 32'(exp_e[i]));
    end

    // Backpressure: redirect the held word at 0xC away, then hold the lw at 4
    wait_valid0("bp_hold12");
    exp_addr_q.push_back(32'h4);
    if0.redirect_valid = 1'b1;
    if0.redirect_pc    = 32'h4;
    tick();
    if0.redirect_valid = 1'b0;
    wait_valid0("bp_hold4");
    check_val("bp_inst", if0.inst, 32'h8C01_0004);
    held_inst = if0.inst;
    held_pc   = if0.inst_pc;
    r0        = req_cnt;
    repeat (5) begin
      tick();
      check_val("bp_stable_inst", if0.inst, held_inst);
      check_val("bp_stable_pc", if0.inst_pc, held_pc);
      check_val("bp_no_req", 32'(if0.imem_req), 32'd0);
    end
    check_val("bp_req_cnt", 32'(req_cnt), 32'(r0));
    h0 = hand_cnt;
    exp_inst_q.push_back('{pc: 32'h4});
    exp_addr_q.push_back(32'h8);
    if0.inst_ready = 1'b1;
    tick();
    if0.inst_ready = 1'b0;
    repeat (2) tick();
    check_val("bp_one_handoff", 32'(hand_cnt), 32'(h0 + 1));
    wait_valid0("bp_hold8");

    // Redirect in WAIT with L=3
    lat = 3;
    exp_inst_q.push_back('{pc: 32'h8});
    exp_addr_q.push_back(32'hC);
    if0.inst_ready = 1'b1;
    tick();
    if0.inst_ready = 1'b0;
    check_val("rw_req", 32'(if0.imem_req), 32'd1);
    tick();
    exp_addr_q.push_back(32'h40);
    if0.redirect_valid = 1'b1;
    if0.redirect_pc    = 32'h0000_0043;
    tick();
    if0.redirect_valid = 1'b0;
    wait_valid0("rw_hold");
    check_val("rw_inst_pc", if0.inst_pc, 32'h40);
    check_val("rw_inst", if0.inst, mem_word(32'h40));

    // Simultaneous handoff and redirect
    lat = 1;
    exp_addr_q.push_back(32'h20);
    if0.redirect_valid = 1'b1;
    if0.redirect_pc    = 32'h20;
    tick();
    if0.redirect_valid = 1'b0;
    wait_valid0("hr_hold20");
    check_val("hr_inst_pc", if0.inst_pc, 32'h20);
    h0 = hand_cnt;
    exp_inst_q.push_back('{pc: 32'h20});
    exp_addr_q.push_back(32'h100);
    if0.inst_ready     = 1'b1;
    if0.redirect_valid = 1'b1;
    if0.redirect_pc    = 32'h100;
    tick();
    if0.inst_ready     = 1'b0;
    if0.redirect_valid = 1'b0;
    check_val("hr_handoff", 32'(hand_cnt), 32'(h0 + 1));
    wait_valid0("hr_hold100");
    check_val("hr_inst_pc100", if0.inst_pc, 32'h100);

    // Redirect coincident with the response
    exp_inst_q.push_back('{pc: 32'h100});
    exp_addr_q.push_back(32'h104);
    if0.inst_ready = 1'b1;
    tick();
    if0.inst_ready = 1'b0;
    check_val("rc_req", 32'(if0.imem_req), 32'd1);
    tick();
    exp_addr_q.push_back(32'h200);
    if0.redirect_valid = 1'b1;
    if0.redirect_pc    = 32'h200;
    tick();
    if0.redirect_valid = 1'b0;
    check_val("rc_req_next", 32'(if0.imem_req), 32'd1);
    check_val("rc_addr_next", if0.imem_addr, 32'h200);
    check_val("rc_no_valid", 32'(if0.inst_valid), 32'd0);
    wait_valid0("rc_hold200");
    check_val("rc_inst_pc", if0.inst_pc, 32'h200);
    check_val("rc_inst", if0.inst, mem_word(32'h200));

    // PC wrap on the second instance
    exp_addr_q.push_back(32'h0);
    resetn         = 1'b0;
    if1.inst_ready = 1'b0;
    repeat (2) tick();
    check_val("wrap_rst_addr", if1.imem_addr, 32'hFFFF_FFFC);
    check_val("wrap_rst_req", 32'(if1.imem_req), 32'd0);
    check_val("wrap_rst_plus4", if1.pc_plus4, 32'h4);
    if1.inst_ready = 1'b1;
    resetn         = 1'b1;
    wait_req1("wrap_req0");
    check_val("wrap_addr0", if1.imem_addr, 32'hFFFF_FFFC);
    wait_valid1("wrap_valid0");
    check_val("wrap_inst_pc0", if1.inst_pc, 32'hFFFF_FFFC);
    check_val("wrap_plus4_0", if1.pc_plus4, 32'h0);
    tick();
    if1.inst_ready = 1'b0;
    wait_req1("wrap_req1");
    check_val("wrap_addr1", if1.imem_addr, 32'h0);
    wait_valid1("wrap_valid1");
    check_val("wrap_inst_pc1", if1.inst_pc, 32'h0);
    check_val("wrap_inst1", if1.inst, mem_word(32'h0));
    repeat (3) tick();
    check_val("wrap_plus4_1", if1.pc_plus4, 32'h4);
    check_val("wrap_still_valid", 32'(if1.inst_valid), 32'd1);

    repeat (3) tick();
    check_val("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
    check_val("inst_q_drained", 32'(exp_inst_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage of the MIPS datapath, sitting directly upstream of the main decoder. It holds the PC, issues one word request at a time to instruction memory, and presents the returned instruction (whose `inst[31:26]` drives the decoder `op`) on a valid/ready handshake. Control-flow redirects (taken branch or jump, produced from the decoder's `pcsrc`/`jump` path) steer the next fetch and squash any in-flight or held instruction.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `imem_req` out 1: one-cycle request strobe; memory always accepts.
- `imem_addr` out 32: word address of the request; equals the PC register.
- `imem_rvalid` in 1: response strobe, at least 1 cycle after `imem_req`.
- `imem_rdata` in 32: instruction word, valid with `imem_rvalid`.
- `redirect_valid` in 1: taken branch or jump this cycle.
- `redirect_pc` in 32: target; bits [1:0] ignored and forced to 00.
- `inst_valid` out 1: `inst`/`inst_pc`/`pc_plus4` valid.
- `inst_ready` in 1: downstream accepts this cycle.
- `inst` out 32: fetched instruction.
- `inst_pc` out 32: address of `inst`.
- `pc_plus4` out 32: `inst_pc + 4`, for the branch adder.

## Operation
- States: IDLE, REQ, WAIT, HOLD. Registers: `pc`, `kill`, `inst_r`, `inst_pc_r`.
- IDLE → REQ unconditionally; this is the reset state.
- In REQ, `imem_req`=1 and `imem_addr`=`pc`; the state moves to WAIT.
- In WAIT, on `imem_rvalid` with `kill`=0, capture `imem_rdata` into `inst_r` and `pc` into `inst_pc_r`, then go to HOLD.
- In WAIT, on `imem_rvalid` with `kill`=1, discard the data, clear `kill` and go to REQ.
- In HOLD, `inst_valid`=1. On `inst_ready`, the handoff completes, `pc` becomes `pc+4` and the state goes to REQ.
- Redirect has priority over sequential next-PC. On `redirect_valid`, `pc` ← {`redirect_pc[31:2]`, 2'b00}, with the following per-state behaviour:
  - In REQ, the request issued this cycle gets `kill` set.
  - In WAIT without `imem_rvalid`, set `kill`. With `imem_rvalid` in the same cycle, discard the data and go to REQ.
  - In HOLD with `inst_ready`, the handoff completes (the consumer owns it) and the next fetch is the target.
  - In HOLD without `inst_ready`, drop the held instruction and go to REQ.
  - In IDLE, load `pc` only.
- Multiple redirects while `kill`=1: the latest target wins, and only one response is discarded.
- `pc+4` wraps modulo 2^32: 32'hFFFF_FFFC → 32'h0000_0000.
- At most one outstanding request. `imem_req` is never asserted in WAIT or HOLD.
- `imem_rvalid` outside WAIT is ignored.

## Timing
- Every output is registered or decoded from state only. There is no combinational path from `inst_ready`, `redirect_valid` or `imem_rvalid` to any output.
- Reset (`resetn`=0 at a rising edge) puts the block in IDLE with `pc`=`RESET_PC`, `kill`=0, `inst_r`=0 and `inst_pc_r`=0.
- Output values during and after reset: `imem_req`=0, `imem_addr`=`RESET_PC`, `inst_valid`=0, `inst`=0, `inst_pc`=0, `pc_plus4`=4.
- A reset mid-WAIT abandons the request. A late `imem_rvalid` arriving in IDLE or REQ is ignored.
- First `imem_req` comes 1 cycle after the first edge with `resetn`=1.
- Fetch latency with memory latency L≥1: `imem_req` at cycle t, `imem_rvalid` at t+L, `inst_valid` at t+L+1.
- Peak throughput with L=1 and `inst_ready` held at 1 is one instruction per 3 cycles.
- `inst`, `inst_pc` and `pc_plus4` stay stable while `inst_valid`=1 and `inst_ready`=0.
- `inst_valid` deasserts the cycle after a handoff, or the cycle after a redirect in HOLD.

## Test plan
- **Reset sequence.** Apply `RESET_PC`=0, hold `resetn`=0 for 3 cycles, then release, with L=1 and `inst_ready`=1. Required response:
  - `imem_req` at addresses 0, 4, 8 on cycles 1, 4, 7 after release.
  - `inst_pc` matches each address, and `pc_plus4` = address+4.
- **Backpressure.** Hold `inst_ready`=0 for 5 cycles in HOLD with `inst`=32'h8C01_0004 (lw). Required response:
  - `inst` and `inst_pc` stay stable and no `imem_req` is issued.
  - The ready pulse causes exactly one handoff, followed by a request at `inst_pc`+4.
- **Redirect in WAIT (L=3).** Assert `redirect_valid` with `redirect_pc`=32'h0000_0043 one cycle after `imem_req`. Required response:
  - The returned word is never presented.
  - The next `imem_addr` is 32'h0000_0040.
- **Simultaneous handoff and redirect.** Present `inst_ready`=1 and `redirect_valid`=1 in HOLD, with target 32'h100 and `inst_pc`=32'h20. Required response:
  - The instruction at 32'h20 is accepted.
  - The next request is 32'h100, not 32'h24.
- **Redirect coincident with response.** Assert `redirect_valid` in the same cycle as `imem_rvalid`. Required response:
  - The data is dropped.
  - REQ is entered next cycle at the target, and `kill` ends at 0.
- **PC wrap.** Use `RESET_PC`=32'hFFFF_FFFC with one handoff. Required response:
  - The next `imem_addr` is 32'h0000_0000.
  - While that instruction is held, `pc_plus4` reads 32'h0000_0004.
